// File: rtl/ysyx_22040088_muldiv_pkg.sv
// Shared constants for the RV64M multiply/divide sequencer: op bit positions,
// FSM state encoding and default datapath widths.
package ysyx_22040088_muldiv_pkg;

    localparam int unsigned DEF_XLEN = 64;
    localparam int unsigned DEF_WLEN = 32;
    localparam int unsigned OP_W     = 6;

    // Bit positions inside the one-hot op vector (control unit alu_op[16:11])
    localparam int unsigned OP_MUL  = 0;
    localparam int unsigned OP_DIV  = 1;
    localparam int unsigned OP_REM  = 2;
    localparam int unsigned OP_MULU = 3;
    localparam int unsigned OP_DIVU = 4;
    localparam int unsigned OP_REMU = 5;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_DIV  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_e;

endpackage

// File: rtl/ysyx_22040088_muldiv_if.sv
// Request/response bundle between EXU (master) and the mul/div sequencer (slave).
interface ysyx_22040088_muldiv_if
    import ysyx_22040088_muldiv_pkg::*;
#(
    parameter int unsigned XLEN = DEF_XLEN
) ();

    logic            in_valid;
    logic            in_ready;
    logic [OP_W-1:0] op;
    logic            word;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    modport master (
        output in_valid, op, word, src1, src2, flush, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, op, word, src1, src2, flush, out_ready,
        output in_ready, out_valid, result, busy
    );

endinterface

// File: rtl/ysyx_22040088_muldiv_dp.sv
// Iterative datapath: shift-add multiplier and restoring divider sharing one
// accumulator / operand / shift register set, one bit per step.
module ysyx_22040088_muldiv_dp #(
    parameter int unsigned XLEN = 64,
    parameter int unsigned WLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
    input  logic            mul_mode,
    input  logic            word,
    input  logic [XLEN-1:0] opa,
    input  logic [XLEN-1:0] opb,
    output logic [XLEN-1:0] acc,
    output logic [XLEN-1:0] quo
);

    logic [XLEN-1:0] opnd;   // multiplicand (shifts left) or divisor (fixed)
    logic [XLEN-1:0] shreg;  // multiplier (shifts right) or dividend/quotient (shifts left)
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;
    logic            trial_ok;

    // Trial subtract of the divisor from the partial remainder shifted by one
    always_comb begin
        shifted  = {acc, shreg[XLEN-1]};
        diff     = shifted - {1'b0, opnd};
        trial_ok = ~diff[XLEN];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= '0;
            opnd  <= '0;
            shreg <= '0;
        end else if (load) begin
            acc <= '0;
            if (mul_mode) begin
                opnd  <= opa;
                shreg <= opb;
            end else begin
                opnd  <= opb;
                // word divides run WLEN steps, so the dividend starts left-justified
                shreg <= word ? (opa << (XLEN - WLEN)) : opa;
            end
        end else if (step) begin
            if (mul_mode) begin
                acc   <= acc + (shreg[0] ? opnd : '0);
                opnd  <= opnd << 1;
                shreg <= shreg >> 1;
            end else begin
                acc   <= trial_ok ? diff[XLEN-1:0] : shifted[XLEN-1:0];
                shreg <= {shreg[XLEN-2:0], trial_ok};
            end
        end
    end

    assign quo = shreg;

endmodule

// File: rtl/ysyx_22040088_muldiv_seq.sv
// RV64M multi-cycle mul/div/rem sequencer: operand conditioning, special-case
// shortcuts, iteration control, sign fix-up and result hold until consumed.
module ysyx_22040088_muldiv_seq
    import ysyx_22040088_muldiv_pkg::*;
#(
    parameter int unsigned XLEN = DEF_XLEN,
    parameter int unsigned WLEN = DEF_WLEN
) (
    input logic                      clk,
    input logic                      rst,
    ysyx_22040088_muldiv_if.slave    bus
);

    localparam int unsigned CW = $clog2(XLEN);
    localparam logic [WLEN-1:0] W_MIN = {1'b1, {(WLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] X_MIN = {1'b1, {(XLEN-1){1'b0}}};

    function automatic logic [XLEN-1:0] sext_w(input logic [WLEN-1:0] v);
        return {{(XLEN-WLEN){v[WLEN-1]}}, v};
    endfunction

    state_e          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt, k_last;
    logic [XLEN-1:0] result_q, result_nxt;
    logic            word_q, word_nxt, sel_quo_q, sel_quo_nxt;
    logic            qneg_q, qneg_nxt, rneg_q, rneg_nxt;

    logic [XLEN-1:0] ext1, ext2, mag1, mag2, fix_raw, fix_val;
    logic            sgn_op, s1, s2, illegal, div_zero, ovf, quo_op;
    logic            dp_load, dp_step, dp_mul;
    logic [XLEN-1:0] dp_acc, dp_quo;

    // Request decode: operand extension, magnitudes and shortcut detection
    always_comb begin
        sgn_op   = bus.op[OP_MUL] | bus.op[OP_DIV] | bus.op[OP_REM];
        quo_op   = bus.op[OP_DIV] | bus.op[OP_DIVU];
        ext1     = bus.word ? (sgn_op ? sext_w(bus.src1[WLEN-1:0]) : XLEN'(bus.src1[WLEN-1:0])) : bus.src1;
        ext2     = bus.word ? (sgn_op ? sext_w(bus.src2[WLEN-1:0]) : XLEN'(bus.src2[WLEN-1:0])) : bus.src2;
        s1       = sgn_op & ext1[XLEN-1];
        s2       = sgn_op & ext2[XLEN-1];
        mag1     = s1 ? -ext1 : ext1;
        mag2     = s2 ? -ext2 : ext2;
        illegal  = !$onehot(bus.op) || bus.op[OP_MULU];
        div_zero = !bus.op[OP_MUL] && (ext2 == '0);
        ovf      = (bus.op[OP_DIV] | bus.op[OP_REM]) &&
                   (bus.word ? (bus.src1[WLEN-1:0] == W_MIN && bus.src2[WLEN-1:0] == '1)
                             : (bus.src1 == X_MIN && bus.src2 == '1));
    end

    // Fix-up: sign correction, quotient/remainder select, word sign-extension
    always_comb begin
        fix_raw = sel_quo_q ? dp_quo : dp_acc;
        fix_val = (sel_quo_q ? qneg_q : rneg_q) ? -fix_raw : fix_raw;
        if (word_q) fix_val = sext_w(fix_val[WLEN-1:0]);
    end

    assign k_last = word_q ? CW'(WLEN - 1) : CW'(XLEN - 1);

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        result_nxt  = result_q;
        word_nxt    = word_q;
        sel_quo_nxt = sel_quo_q;
        qneg_nxt    = qneg_q;
        rneg_nxt    = rneg_q;
        dp_load     = 1'b0;
        unique case (state)
            S_IDLE: if (bus.in_valid) begin
                word_nxt    = bus.word;
                sel_quo_nxt = quo_op;
                qneg_nxt    = s1 ^ s2;
                rneg_nxt    = s1 & !bus.op[OP_MUL];
                cnt_nxt     = '0;
                if (illegal) begin
                    state_nxt  = S_DONE;
                    result_nxt = '0;
                end else if (div_zero) begin
                    state_nxt  = S_DONE;
                    result_nxt = quo_op ? '1 : (bus.word ? sext_w(bus.src1[WLEN-1:0]) : bus.src1);
                end else if (ovf) begin
                    state_nxt  = S_DONE;
                    result_nxt = quo_op ? ext1 : '0;
                end else begin
                    state_nxt = bus.op[OP_MUL] ? S_MUL : S_DIV;
                    dp_load   = 1'b1;
                end
            end
            S_MUL, S_DIV: begin
                cnt_nxt = cnt + CW'(1);
                if (cnt == k_last) begin
                    cnt_nxt   = '0;
                    state_nxt = S_FIX;
                end
            end
            S_FIX: begin
                result_nxt = fix_val;
                state_nxt  = S_DONE;
            end
            S_DONE: if (bus.out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        // Abort overrides everything except reset
        if (bus.flush) begin
            state_nxt  = S_IDLE;
            cnt_nxt    = '0;
            result_nxt = '0;
            dp_load    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            cnt           <= '0;
            result_q      <= '0;
            word_q        <= 1'b0;
            sel_quo_q     <= 1'b0;
            qneg_q        <= 1'b0;
            rneg_q        <= 1'b0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            result_q      <= result_nxt;
            word_q        <= word_nxt;
            sel_quo_q     <= sel_quo_nxt;
            qneg_q        <= qneg_nxt;
            rneg_q        <= rneg_nxt;
            bus.in_ready  <= (state_nxt == S_IDLE);
            bus.out_valid <= (state_nxt == S_DONE);
            bus.busy      <= (state_nxt != S_IDLE);
        end
    end

    assign bus.result = result_q;

    assign dp_step = (state == S_MUL) || (state == S_DIV);
    assign dp_mul  = (state == S_IDLE) ? bus.op[OP_MUL] : (state == S_MUL);

    ysyx_22040088_muldiv_dp #(.XLEN(XLEN), .WLEN(WLEN)) u_dp (
        .clk      (clk),
        .rst      (rst),
        .load     (dp_load),
        .step     (dp_step),
        .mul_mode (dp_mul),
        .word     (bus.word),
        .opa      (bus.op[OP_MUL] ? ext1 : mag1),
        .opb      (bus.op[OP_MUL] ? ext2 : mag2),
        .acc      (dp_acc),
        .quo      (dp_quo)
    );

endmodule

// File: tb/tb_ysyx_22040088_muldiv_seq.sv
// Directed bench for the mul/div sequencer: results, latency, special cases,
// back-pressure, flush and reset.
module tb_ysyx_22040088_muldiv_seq;

    localparam logic [5:0] MUL  = 6'b000001;
    localparam logic [5:0] DIV  = 6'b000010;
    localparam logic [5:0] REM  = 6'b000100;
    localparam logic [5:0] MULU = 6'b001000;
    localparam logic [5:0] DIVU = 6'b010000;
    localparam logic [5:0] REMU = 6'b100000;

    logic clk;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    ysyx_22040088_muldiv_if #(.XLEN(64)) bus ();

    ysyx_22040088_muldiv_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    // Handshake at cycle 0, then wait (bounded) for out_valid; lat is the cycle it rose
    task automatic run_op(input logic [5:0] o, input logic w, input logic [63:0] a,
                          input logic [63:0] b, output logic [63:0] res, output int lat);
        @(negedge clk);
        bus.in_valid = 1'b1; bus.op = o; bus.word = w; bus.src1 = a; bus.src2 = b;
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.src1 = ~a; bus.src2 = ~b; bus.op = MUL; bus.word = ~w;
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        res = bus.result;
    endtask

    task automatic consume();
        @(negedge clk); bus.out_ready = 1'b1;
        @(posedge clk); #1; bus.out_ready = 1'b0;
    endtask

    task automatic do_op(input string tag, input logic [5:0] o, input logic w,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] exp_res, input int exp_lat);
        logic [63:0] res;
        int          lat;
        run_op(o, w, a, b, res, lat);
        chk({tag, "_res"}, res, exp_res);
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        consume();
    endtask

    initial begin
        logic [63:0] res;
        int          lat;
        int          seen;

        rst = 1'b1;
        bus.in_valid = 1'b0; bus.op = '0; bus.word = 1'b0; bus.src1 = '0; bus.src2 = '0;
        bus.flush = 1'b0; bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_result", bus.result, 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);

        do_op("mul_7_m3", MUL, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 66);
        do_op("div_m7_2", DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66);
        do_op("rem_m7_2", REM, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66);
        do_op("divu_100_7", DIVU, 1'b0, 64'd100, 64'd7, 64'd14, 66);
        do_op("remu_100_7", REMU, 1'b0, 64'd100, 64'd7, 64'd2, 66);
        do_op("divu_by0", DIVU, 1'b0, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        do_op("remu_by0", REMU, 1'b0, 64'h1234, 64'd0, 64'h1234, 1);
        do_op("illegal_2hot", 6'b000011, 1'b0, 64'd9, 64'd3, 64'd0, 1);
        do_op("div_ovf", DIV, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
              64'h8000_0000_0000_0000, 1);
        do_op("rem_ovf", REM, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1);
        do_op("mulw", MUL, 1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 34);
        do_op("mulu_illegal", MULU, 1'b0, 64'd5, 64'd6, 64'd0, 1);
        do_op("remw_ovf", REM, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'd0, 1);
        do_op("divw_m7_2", DIV, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 34);

        // Back-pressure: result held and no new accept while out_ready is low
        run_op(DIVU, 1'b0, 64'd100, 64'd7, res, lat);
        chk("bp_lat", 64'(lat), 64'd66);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_result", bus.result, 64'd14);
            chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
            chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
        end
        consume();
        chk("bp_rel_out_valid", 64'(bus.out_valid), 64'd0);
        chk("bp_rel_in_ready", 64'(bus.in_ready), 64'd1);
        chk("bp_rel_busy", 64'(bus.busy), 64'd0);

        // Flush in IDLE drops a simultaneous request and clears the result
        @(negedge clk);
        bus.in_valid = 1'b1; bus.flush = 1'b1; bus.op = DIVU; bus.word = 1'b0;
        bus.src1 = 64'd50; bus.src2 = 64'd5;
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.flush = 1'b0;
        chk("fidle_busy", 64'(bus.busy), 64'd0);
        chk("fidle_result", bus.result, 64'd0);
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid === 1'b1 || bus.busy === 1'b1) seen++;
        end
        chk("fidle_no_activity", 64'(seen), 64'd0);

        // Flush at cycle 20 of a divide
        @(negedge clk);
        bus.in_valid = 1'b1; bus.op = DIV; bus.word = 1'b0;
        bus.src1 = 64'hFFFF_FFFF_FFFF_FFF9; bus.src2 = 64'd2;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (19) @(posedge clk);
        #1 chk("fl_busy_c20", 64'(bus.busy), 64'd1);
        @(negedge clk); bus.flush = 1'b1;
        @(posedge clk); #1; bus.flush = 1'b0;
        chk("fl_busy_c21", 64'(bus.busy), 64'd0);
        chk("fl_in_ready_c21", 64'(bus.in_ready), 64'd1);
        chk("fl_out_valid_c21", 64'(bus.out_valid), 64'd0);
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid === 1'b1) seen++;
        end
        chk("fl_no_out_valid", 64'(seen), 64'd0);

        // Reset at cycle 30 of a multiply, with a nonzero result held from before
        do_op("remu_pre_rst", REMU, 1'b0, 64'd100, 64'd7, 64'd2, 66);
        @(negedge clk);
        bus.in_valid = 1'b1; bus.op = MUL; bus.word = 1'b0; bus.src1 = 64'd3; bus.src2 = 64'd4;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (29) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk("rst30_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst30_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst30_result", bus.result, 64'd0);
        chk("rst30_busy", 64'(bus.busy), 64'd0);
        @(negedge clk); rst = 1'b0;

        // Sequencer is usable again after reset
        do_op("mul_after_rst", MUL, 1'b0, 64'd3, 64'd4, 64'd12, 66);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_22040088_muldiv_seq.md
Name: ysyx_22040088_muldiv_seq

Overview:
Multi-cycle sequencer for the RV64M multiply/divide/remainder operations decoded by the control unit (mul, div, divu, rem, remu and their W forms). It accepts one operation per valid/ready handshake and iterates a shift-add multiplier or a restoring divider for 32 or 64 steps. It applies sign fix-up and word sign-extension, then holds the result until the execute stage consumes it. It sits beside the single-cycle ALU in EXU and stalls the pipeline via in_ready/out_valid.

Parameters:
XLEN, 64, datapath width; iteration count for non-word ops
WLEN, 32, word-op width; iteration count for W ops

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  operation request
in_ready  out  1  sequencer can accept (IDLE only)
op  in  6  one-hot {remu, divu, mulu(reserved), rem, div, mul}, same order as the control unit's alu_op[16:11]
word  in  1  W variant (operate on [31:0], sign-extend result)
src1  in  XLEN  rs1 value
src2  in  XLEN  rs2 value
flush  in  1  abort current operation
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
result  out  XLEN  product low half / quotient / remainder
busy  out  1  state != IDLE

Behaviour:
- Reset and polarity: reset is synchronous and active-high; one clock, clk; reset port rst.
- Reset values: state=IDLE, in_ready=1, out_valid=0, result=0, busy=0, counter=0.
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE:
  - Handshake (in_valid & in_ready) latches op, word and operands.
  - Word ops: operands are sign-extended from [31:0] for signed ops and zero-extended for divu/remu.
- Next state from IDLE, first matching rule wins:
  - Illegal op (not one-hot, or mulu set) -> DONE, result=0.
  - Divide by zero -> DONE with quotient=all ones, remainder=dividend (word: sign-extended [31:0]).
  - Signed overflow (min / -1, at the 64- or 32-bit width) -> DONE with quotient=dividend, remainder=0.
  - mul -> MUL.
  - Otherwise -> DIV.
- MUL: unsigned shift-add on the raw operands, one multiplier bit per cycle, K cycles (K=WLEN if word, else XLEN). Only the low XLEN bits are kept, so no sign handling is needed.
- DIV:
  - Restoring divide on magnitudes, K cycles; signed ops take |src1| and |src2|.
  - Record qneg = s1^s2 and rneg = s1.
- Counter: counts 0..K-1 and leaves MUL/DIV when counter==K-1.
- FIX (1 cycle):
  - Negate the quotient if qneg and the remainder if rneg.
  - Select the quotient or remainder.
  - Word ops sign-extend bit 31 into result.
  - Then -> DONE.
- DONE:
  - out_valid=1; result is stable until out_ready.
  - out_valid & out_ready -> IDLE.
  - in_ready=0 in DONE (no same-cycle re-accept).
- Latency, with the handshake at cycle 0:
  - Normal ops: out_valid first high at cycle K+2 (66 for 64-bit, 34 for word).
  - Special cases: out_valid at cycle 1.
- flush: from any state, next cycle state=IDLE and out_valid=0; the result register is cleared.
- Flush priorities:
  - flush in IDLE with in_valid: the request is dropped.
  - rst dominates flush.
  - flush dominates an out_ready handshake in the same cycle.
- Inputs are ignored outside IDLE; operand changes after acceptance have no effect.

Decomposition:
- Package ysyx_22040088_muldiv_pkg holds:
  - op bit indices (OP_MUL=0, OP_DIV=1, OP_REM=2, OP_MULU=3, OP_DIVU=4, OP_REMU=5);
  - state encoding;
  - XLEN/WLEN defaults.
- Sub-module ysyx_22040088_muldiv_dp holds the accumulator/partial-remainder/shift registers and one-step add / trial-subtract logic.
- The sequencer keeps the FSM, counter, special-case detection and fix-up.

Test Plan:
- mul, src1=7, src2=0xFFFFFFFFFFFFFFFD -> result 0xFFFFFFFFFFFFFFEB (-21); out_valid first at cycle 66.
- div and rem, src1=-7, src2=2 -> quotient 0xFFFFFFFFFFFFFFFD (-3), remainder 0xFFFFFFFFFFFFFFFF (-1); divu 100/7 -> 14, remu -> 2.
- Special cases at cycle 1:
  - divu, src2=0, src1=0x1234 -> result 0xFFFFFFFFFFFFFFFF; remu -> 0x1234.
  - div 0x8000000000000000 / -1 -> 0x8000000000000000; rem -> 0.
- Word ops:
  - mul with word=1, 0x7FFFFFFF*2 -> 0xFFFFFFFFFFFFFFFE at cycle 34.
  - rem with word=1, 0x80000000 / 0xFFFFFFFF -> 0.
  - div with word=1, 0x00000000FFFFFFF9 / 2 -> 0xFFFFFFFFFFFFFFFD.
- Back-pressure and flush:
  - Hold out_ready=0 for 10 cycles -> result stable, in_ready=0; on release, IDLE the next cycle.
  - flush at cycle 20 of a div -> IDLE at cycle 21, no out_valid.
  - rst at cycle 30 -> all outputs at reset values.
